mem_arbiter: RTL and testbench

- Two-client arbiter sharing one `memory` port (valid/ready request, res_valid/res_ready response). Client 0 = instruction fetch, client 1 = load/store unit.
- Holds at most one outstanding transaction. Accepts a client request, replays it to memory, then routes the memory response back to the owning client.
- Sits between the CPU front-end/LSU and the memory model.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of a single memory port: one outstanding transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise client 0 wins ties.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] i_c0_address,
    input  logic [DATA_WIDTH-1:0]    i_c0_data,
    input  logic                     i_c0_cmd,
    input  logic                     i_c0_valid,
    output logic                     o_c0_ready,
    output logic [DATA_WIDTH-1:0]    o_c0_data,
    output logic                     o_c0_res_valid,
    input  logic                     i_c0_res_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_c1_address,
    input  logic [DATA_WIDTH-1:0]    i_c1_data,
    input  logic                     i_c1_cmd,
    input  logic                     i_c1_valid,
    output logic                     o_c1_ready,
    output logic [DATA_WIDTH-1:0]    o_c1_data,
    output logic                     o_c1_res_valid,
    input  logic                     i_c1_res_ready,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0]    o_mem_data,
    output logic                     o_mem_cmd,
    output logic                     o_mem_valid,
    input  logic                     i_mem_ready,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    input  logic                     i_mem_res_valid,
    output logic                     o_mem_res_ready,
    output logic                     o_grant,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_grant;
    logic                     r_last_grant;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_cmd;

    logic w_pick_valid;
    logic w_pick;
    logic w_accept;
    logic w_idle;
    logic w_wait;
    logic w_res_ready;

    always_comb begin
        w_pick_valid = i_c0_valid | i_c1_valid;
        w_pick       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_c0_valid && i_c1_valid) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = i_c1_valid;
        end
`else
        w_pick = ~i_c0_valid & i_c1_valid;
`endif
    end

    assign w_idle      = (r_state == S_IDLE);
    assign w_wait      = (r_state == S_WAIT);
    assign w_accept    = w_idle && w_pick_valid;
    assign w_res_ready = r_grant ? i_c1_res_ready : i_c0_res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_address    <= '0;
            r_data       <= '0;
            r_cmd        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_address    <= w_pick ? i_c1_address : i_c0_address;
                r_data       <= w_pick ? i_c1_data    : i_c0_data;
                r_cmd        <= w_pick ? i_c1_cmd     : i_c0_cmd;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (i_mem_ready) w_next = S_WAIT;
            S_WAIT:  if (i_mem_res_valid && w_res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Readies are masked by reset so nothing is offered while the arbiter is held in reset.
    always_comb begin
        o_c0_ready      = ~reset && w_idle && w_pick_valid && ~w_pick;
        o_c1_ready      = ~reset && w_idle && w_pick_valid && w_pick;
        o_c0_res_valid  = w_wait && i_mem_res_valid && ~r_grant;
        o_c1_res_valid  = w_wait && i_mem_res_valid && r_grant;
        o_c0_data       = (w_wait && ~r_grant) ? i_mem_data : '0;
        o_c1_data       = (w_wait && r_grant)  ? i_mem_data : '0;
        o_mem_res_ready = w_wait && w_res_ready;
        o_mem_valid     = (r_state == S_ISSUE);
        o_mem_address   = r_address;
        o_mem_data      = r_data;
        o_mem_cmd       = r_cmd;
        o_grant         = r_grant;
        o_busy          = ~w_idle;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
    logic          c0_cmd = 1'b0, c1_cmd = 1'b0;
    logic          c0_valid = 1'b0, c1_valid = 1'b0;
    logic          c0_res_ready = 1'b0, c1_res_ready = 1'b0;
    logic          mem_ready = 1'b0, mem_res_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          c0_ready, c1_ready, c0_res_valid, c1_res_valid;
    logic [DW-1:0] c0_rdata, c1_rdata, mem_wdata;
    logic [AW-1:0] mem_address;
    logic          mem_cmd, mem_valid, mem_res_ready, grant, busy;

    mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_c0_address(c0_addr), .i_c0_data(c0_wdata), .i_c0_cmd(c0_cmd), .i_c0_valid(c0_valid),
        .o_c0_ready(c0_ready), .o_c0_data(c0_rdata), .o_c0_res_valid(c0_res_valid),
        .i_c0_res_ready(c0_res_ready),
        .i_c1_address(c1_addr), .i_c1_data(c1_wdata), .i_c1_cmd(c1_cmd), .i_c1_valid(c1_valid),
        .o_c1_ready(c1_ready), .o_c1_data(c1_rdata), .o_c1_res_valid(c1_res_valid),
        .i_c1_res_ready(c1_res_ready),
        .o_mem_address(mem_address), .o_mem_data(mem_wdata), .o_mem_cmd(mem_cmd),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .i_mem_data(mem_rdata),
        .i_mem_res_valid(mem_res_valid), .o_mem_res_ready(mem_res_ready),
        .o_grant(grant), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner of the bus (-1 = free), whether the request has reached memory.
    int            m_owner = -1;
    bit            m_sent = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_cmd = 1'b0;
    logic          m_last = 1'b1;
    logic          m_grant = 1'b0;

    function automatic int m_pick();
        if (c0_valid && c1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (m_last == 1'b0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (c0_valid) return 0;
        if (c1_valid) return 1;
        return -1;
    endfunction

    initial forever begin
        @(posedge reset);
        m_owner = -1; m_sent = 1'b0; m_addr = '0; m_data = '0; m_cmd = 1'b0;
        m_last = 1'b1; m_grant = 1'b0;
    end

    initial forever begin
        int p;
        @(posedge clk);
        if (!reset) begin
            if (m_owner < 0) begin
                p = m_pick();
                if (p >= 0) begin
                    m_owner = p;
                    m_sent  = 1'b0;
                    m_grant = p[0];
                    m_last  = p[0];
                    m_addr  = (p == 1) ? c1_addr  : c0_addr;
                    m_data  = (p == 1) ? c1_wdata : c0_wdata;
                    m_cmd   = (p == 1) ? c1_cmd   : c0_cmd;
                end
            end else if (!m_sent) begin
                if (mem_ready) m_sent = 1'b1;
            end else if (mem_res_valid && ((m_owner == 1) ? c1_res_ready : c0_res_ready)) begin
                m_owner = -1;
            end
        end
    end

    initial forever begin
        int p;
        bit idle, wt;
        logic [7:0] exp_ctl, act_ctl;
        @(negedge clk);
        idle = (m_owner < 0);
        wt   = !idle && m_sent;
        p    = idle ? m_pick() : -1;
        exp_ctl = {!reset && p == 0, !reset && p == 1,
                   wt && mem_res_valid && m_owner == 0, wt && mem_res_valid && m_owner == 1,
                   !idle && !m_sent, wt && ((m_owner == 1) ? c1_res_ready : c0_res_ready),
                   !idle, m_grant};
        act_ctl = {c0_ready, c1_ready, c0_res_valid, c1_res_valid,
                   mem_valid, mem_res_ready, busy, grant};
        chk("model_ctl", act_ctl, exp_ctl);
        chk("model_mem_address", mem_address, m_addr);
        chk("model_mem_data", mem_wdata, m_data);
        chk("model_mem_cmd", mem_cmd, m_cmd);
        chk("model_c0_data", c0_rdata, (wt && m_owner == 0) ? mem_rdata : '0);
        chk("model_c1_data", c1_rdata, (wt && m_owner == 1) ? mem_rdata : '0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        c0_valid = 1'b0; c1_valid = 1'b0; c0_cmd = 1'b0; c1_cmd = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        c0_res_ready = 1'b0; c1_res_ready = 1'b0;
        mem_ready = 1'b0; mem_res_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        logic g [4];
        int   n;

        // Reset state
        cyc(2);
        reset = 1'b0;
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_valid", mem_valid, 1'b0);
        chk("reset_grant", grant, 1'b0);
        chk("reset_mem_address", mem_address, 32'h0);
        cyc(1);

        // Single c0 read of 0x8
        c0_valid = 1'b1; c0_addr = 32'h8;
        #2 chk("b_c0_ready", c0_ready, 1'b1);
        cyc(1);
        c0_valid = 1'b0; mem_ready = 1'b1;
        #2;
        chk("b_mem_valid", mem_valid, 1'b1);
        chk("b_mem_address", mem_address, 32'h8);
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; mem_rdata = 32'hDEADBEEF; c0_res_ready = 1'b1;
        #2;
        chk("b_c0_res_valid", c0_res_valid, 1'b1);
        chk("b_c0_data", c0_rdata, 32'hDEADBEEF);
        chk("b_c1_res_valid", c1_res_valid, 1'b0);
        cyc(1);
        clear_inputs();
        cyc(1);

        // Both clients held valid for four transactions from reset
        pulse_reset();
        c0_valid = 1'b1; c1_valid = 1'b1; c0_res_ready = 1'b1; c1_res_ready = 1'b1;
        mem_ready = 1'b1; mem_res_valid = 1'b1; mem_rdata = 32'h1234;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if ((c0_ready || c1_ready) && n < 4) begin
                g[n] = c1_ready;
                n++;
            end
            cyc(1);
        end
        chk("c_num_grants", n, 4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("c_grant0", g[0], 1'b0);
        chk("c_grant1", g[1], 1'b1);
        chk("c_grant2", g[2], 1'b0);
        chk("c_grant3", g[3], 1'b1);
`else
        chk("c_grant0", g[0], 1'b0);
        chk("c_grant1", g[1], 1'b0);
        chk("c_grant2", g[2], 1'b0);
        chk("c_grant3", g[3], 1'b0);
`endif
        clear_inputs();
        cyc(4);

        // c1 owns the bus, c0 waits until the c1 response handshake completes
        c1_valid = 1'b1; c1_addr = 32'h10;
        cyc(1);
        c1_valid = 1'b0; mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0; c0_valid = 1'b1; c0_addr = 32'h20;
        #2 chk("d_c0_ready_wait0", c0_ready, 1'b0);
        cyc(1);
        #2 chk("d_c0_ready_wait1", c0_ready, 1'b0);
        cyc(1);
        mem_res_valid = 1'b1; c1_res_ready = 1'b1;
        #2 chk("d_c0_ready_wait2", c0_ready, 1'b0);
        cyc(1);
        mem_res_valid = 1'b0; c1_res_ready = 1'b0;
        #2 chk("d_c0_ready_idle", c0_ready, 1'b1);
        cyc(1);
        c0_valid = 1'b0; mem_ready = 1'b1;
        #2;
        chk("d_grant", grant, 1'b0);
        chk("d_mem_address", mem_address, 32'h20);
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; c0_res_ready = 1'b1;
        cyc(1);
        clear_inputs();
        cyc(1);

        // Response backpressure from c1
        c1_valid = 1'b1; c1_addr = 32'h30;
        cyc(1);
        c1_valid = 1'b0; mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; mem_rdata = 32'h12345678; c1_res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("e_mem_res_ready", mem_res_ready, 1'b0);
            chk("e_busy", busy, 1'b1);
            chk("e_c1_data", c1_rdata, 32'h12345678);
            cyc(1);
        end
        c1_res_ready = 1'b1;
        #2;
        chk("e_mem_res_ready_rise", mem_res_ready, 1'b1);
        chk("e_c1_res_valid", c1_res_valid, 1'b1);
        cyc(1);
        #2 chk("e_busy_done", busy, 1'b0);
        clear_inputs();
        cyc(1);

        // Memory stalls in ISSUE while the client keeps changing its inputs
        c0_valid = 1'b1; c0_addr = 32'h40; c0_wdata = 32'hA5A5; c0_cmd = 1'b1;
        cyc(1);
        c0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c0_addr = 32'h100 + 32'(i); c0_wdata = 32'h0; c0_cmd = 1'b0;
            #2;
            chk("f_mem_valid", mem_valid, 1'b1);
            chk("f_mem_address", mem_address, 32'h40);
            chk("f_mem_data", mem_wdata, 32'hA5A5);
            chk("f_mem_cmd", mem_cmd, 1'b1);
            cyc(1);
        end
        mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; c0_res_ready = 1'b1;
        cyc(1);
        clear_inputs();
        cyc(1);

        // Reset while c1 is in WAIT, then a normal c0 read of 0x4
        c1_valid = 1'b1; c1_addr = 32'h50;
        cyc(1);
        c1_valid = 1'b0; mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; c1_res_ready = 1'b1; mem_rdata = 32'h77;
        reset = 1'b1;
        #1;
        chk("g_busy", busy, 1'b0);
        chk("g_c1_res_valid", c1_res_valid, 1'b0);
        chk("g_c1_data", c1_rdata, 32'h0);
        chk("g_mem_res_ready", mem_res_ready, 1'b0);
        chk("g_grant", grant, 1'b0);
        chk("g_mem_address", mem_address, 32'h0);
        cyc(1);
        reset = 1'b0;
        clear_inputs();
        c0_valid = 1'b1; c0_addr = 32'h4;
        #2 chk("g_c0_ready", c0_ready, 1'b1);
        cyc(1);
        c0_valid = 1'b0; mem_ready = 1'b1;
        #2;
        chk("g_mem_valid", mem_valid, 1'b1);
        chk("g_mem_address_4", mem_address, 32'h4);
        cyc(1);
        mem_ready = 1'b0; mem_res_valid = 1'b1; mem_rdata = 32'h44; c0_res_ready = 1'b1;
        #2;
        chk("g_c0_res_valid", c0_res_valid, 1'b1);
        chk("g_c0_data", c0_rdata, 32'h44);
        cyc(1);
        clear_inputs();
        cyc(1);

        // Randomized traffic, including spurious responses and client input churn
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            c0_valid      = ($urandom_range(99) < 45);
            c1_valid      = ($urandom_range(99) < 45);
            c0_addr       = $urandom;
            c1_addr       = $urandom;
            c0_wdata      = $urandom;
            c1_wdata      = $urandom;
            c0_cmd        = 1'($urandom_range(1));
            c1_cmd        = 1'($urandom_range(1));
            c0_res_ready  = ($urandom_range(99) < 70);
            c1_res_ready  = ($urandom_range(99) < 70);
            mem_ready     = ($urandom_range(99) < 50);
            mem_res_valid = ($urandom_range(99) < 50);
            mem_rdata     = $urandom;
            cyc(1);
        end
        clear_inputs();
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
